// File: rtl/irda_bit_sync_p.sv
// IrDA bit synchronizer: hunts for a rising edge, confirms it, then tracks
// bit-cell phase at OSR samples per bit. It makes a majority decision near
// cell centre and nudges the phase by one sample when edges arrive late or early.
module irda_bit_sync_p #(
  parameter int unsigned OSR       = 5,
  parameter int unsigned LOSS_BITS = 16,
  parameter bit          TRACK_EN  = 1'b1
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic bs_restart,
  input  logic rx_i,
  input  logic fast_enable,
  input  logic invert,
  output logic bs_o,
  output logic bs_valid_o,
  output logic locked_o,
  output logic realign_o
);

  localparam int unsigned CENTER = OSR / 2;
  localparam int unsigned DEC    = CENTER + 1;
  localparam int unsigned PhW    = $clog2(OSR);
  localparam int unsigned OnesW  = $clog2(CENTER + 1);
  localparam int unsigned LossW  = $clog2(LOSS_BITS + 1);

  localparam logic [PhW-1:0]   PhDec   = PhW'(DEC);
  localparam logic [PhW-1:0]   PhLast  = PhW'(OSR - 1);
  localparam logic [PhW-1:0]   PhOne   = PhW'(1);
  localparam logic [OnesW-1:0] OnesLck = OnesW'(CENTER);
  localparam logic [LossW-1:0] LossMax = LossW'(LOSS_BITS);

  typedef enum logic [1:0] {
    StHuntLow,
    StHuntHigh,
    StConfirm,
    StTrack
  } state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   ph_q, ph_d;
  logic [OnesW-1:0] ones_q, ones_d;
  logic [LossW-1:0] loss_q, loss_d;
  logic [2:0]       sh_q, sh_d;
  logic             cell_edge_q, cell_edge_d;
  logic             bs_q, bs_d;
  logic             valid_q, valid_d;
  logic             realign_q, realign_d;

  logic rx_s;
  logic edge_s;
  logic maj_s;

  // Polarity-corrected sample, edge versus previous sample, and 3-sample majority.
  assign rx_s   = rx_i ^ invert;
  assign edge_s = rx_s ^ sh_q[0];
  assign maj_s  = (rx_s & sh_q[0]) | (rx_s & sh_q[1]) | (sh_q[0] & sh_q[1]);

  // Next-state logic: everything advances only on a fast_enable strobe; pulses self-clear.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    ones_d      = ones_q;
    loss_d      = loss_q;
    sh_d        = sh_q;
    cell_edge_d = cell_edge_q;
    bs_d        = bs_q;
    valid_d     = 1'b0;
    realign_d   = 1'b0;

    if (fast_enable) begin
      sh_d = {sh_q[1:0], rx_s};
      unique case (state_q)
        StHuntLow: begin
          if (!rx_s) state_d = StHuntHigh;
        end
        StHuntHigh: begin
          // The rising-edge sample is phase 0 of a bit cell.
          if (rx_s) begin
            state_d = StConfirm;
            ph_d    = '0;
            ones_d  = OnesW'(1);
          end
        end
        StConfirm: begin
          if (!rx_s) begin
            state_d = StHuntHigh;
            ph_d    = '0;
            ones_d  = '0;
          end else if (ones_q == OnesLck) begin
            // This sample sits at phase CENTER; the next one is the decision phase.
            // The confirmed rising edge belongs to the current cell.
            state_d     = StTrack;
            ph_d        = PhDec;
            ones_d      = '0;
            loss_d      = '0;
            cell_edge_d = 1'b1;
          end else begin
            ph_d   = ph_q + PhOne;
            ones_d = ones_q + OnesW'(1);
          end
        end
        StTrack: begin
          ph_d = (ph_q == PhLast) ? '0 : ph_q + PhOne;

          if (ph_q == PhDec) begin
            bs_d    = maj_s;
            valid_d = 1'b1;
          end

          if (edge_s) begin
            loss_d      = '0;
            cell_edge_d = 1'b1;
            // Late (ph=1) or early (ph=OSR-1) edge: treat this sample as phase 0.
            if (TRACK_EN && ((ph_q == PhOne) || (ph_q == PhLast))) begin
              ph_d      = PhOne;
              realign_d = 1'b1;
            end
          end

          if (ph_q == PhLast) begin
            if (!edge_s && !cell_edge_q && (loss_q != LossMax)) loss_d = loss_q + LossW'(1);
            // An edge on the wrap sample starts the new cell, so it counts there.
            cell_edge_d = edge_s;
          end

          if (loss_d == LossMax) begin
            state_d     = StHuntLow;
            ph_d        = '0;
            loss_d      = '0;
            cell_edge_d = 1'b0;
            bs_d        = 1'b0;
            valid_d     = 1'b0;
            realign_d   = 1'b0;
          end
        end
      endcase
    end
  end

  // State register: asynchronous reset, then synchronous restart with priority.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StHuntLow;
      ph_q        <= '0;
      ones_q      <= '0;
      loss_q      <= '0;
      sh_q        <= '0;
      cell_edge_q <= 1'b0;
      bs_q        <= 1'b0;
      valid_q     <= 1'b0;
      realign_q   <= 1'b0;
    end else if (bs_restart) begin
      state_q     <= StHuntLow;
      ph_q        <= '0;
      ones_q      <= '0;
      loss_q      <= '0;
      sh_q        <= '0;
      cell_edge_q <= 1'b0;
      bs_q        <= 1'b0;
      valid_q     <= 1'b0;
      realign_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      ones_q      <= ones_d;
      loss_q      <= loss_d;
      sh_q        <= sh_d;
      cell_edge_q <= cell_edge_d;
      bs_q        <= bs_d;
      valid_q     <= valid_d;
      realign_q   <= realign_d;
    end
  end

  assign bs_o       = bs_q;
  assign bs_valid_o = valid_q;
  assign locked_o   = (state_q == StTrack);
  assign realign_o  = realign_q;

endmodule

// File: doc/irda_bit_sync_p.md
IRDA_BIT_SYNC_P -- requirements
Module: irda_bit_sync_p

Interface
REQ-001 SHALL provide parameter OSR, default 5, meaning fast_enable samples per bit cell; legal range 3..16.
REQ-002 SHALL provide parameter LOSS_BITS, default 16, meaning consecutive edge-free bit cells in TRACK before lock is dropped; legal range 2..255.
REQ-003 SHALL provide parameter TRACK_EN, default 1, meaning 1 enables ±1-sample phase correction on edges and 0 disables it.
REQ-004 SHALL define localparam CENTER = OSR/2 (integer division) and DEC = CENTER+1 (decision phase).
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-007 bs_restart  input  1  synchronous restart to hunt; priority over fast_enable.
REQ-008 rx_i  input  1  raw receiver (LED) input.
REQ-009 fast_enable  input  1  one-clk sample strobe; the block advances only when high.
REQ-010 invert  input  1  polarity select; internal sample rx_s = rx_i XOR invert.
REQ-011 bs_o  output  1  registered recovered bit, valid when bs_valid_o is high.
REQ-012 bs_valid_o  output  1  one-clk pulse per recovered bit.
REQ-013 locked_o  output  1  high while in TRACK.
REQ-014 realign_o  output  1  one-clk pulse when a phase correction is applied.

Function
REQ-015 SHALL implement FSM states HUNT_LOW, HUNT_HIGH, CONFIRM, TRACK; all transitions occur only on clk edges with fast_enable=1.
REQ-016 HUNT_LOW: rx_s=0 -> HUNT_HIGH; otherwise hold.
REQ-017 HUNT_HIGH: rx_s=1 -> CONFIRM with ph=0 and ones count=1 (this rising-edge sample is phase 0 of a bit cell).
REQ-018 CONFIRM: rx_s=0 -> HUNT_HIGH; rx_s=1 -> ph+1 and ones count+1; when the count reaches CENTER+1 -> TRACK, locked_o=1, ph=CENTER.
REQ-019 TRACK: ph increments per enable from 0 to OSR-1 and wraps to 0.
REQ-020 SHALL keep a 3-deep shift register of rx_s samples; it updates on every enable in every state.
REQ-021 At an enable with ph=DEC in TRACK: bs_o <= majority of the 3 most recent samples (including the current one); bs_valid_o pulses high for the following clk only.
REQ-022 Edge = rx_s differs from the previous sample; in TRACK, an edge at ph=0 is nominal with no correction.
REQ-023 With TRACK_EN=1, an edge at ph=1 (late) SHALL make next ph=1 (hold) and pulse realign_o.
REQ-024 With TRACK_EN=1, an edge at ph=OSR-1 (early) SHALL make next ph=1 (skip) and pulse realign_o.
REQ-025 Edges at any other phase, or any edge with TRACK_EN=0, cause no correction.
REQ-026 A decision and a correction on the same enable (ph=DEC=OSR-1 when OSR=3) SHALL both take effect.
REQ-027 Loss counter: cleared on any edge in TRACK; incremented at the ph=OSR-1 wrap if no edge occurred in that cell; saturating, width clog2(LOSS_BITS+1).
REQ-028 When the loss counter reaches LOSS_BITS: state -> HUNT_LOW, locked_o=0, bs_o=0, no bs_valid_o pulse on that enable.
REQ-029 bs_valid_o and realign_o SHALL be low on every clk not immediately following a qualifying enable; there is no back-pressure.
REQ-030 With fast_enable=0, all state, counters and outputs hold, except that pulse outputs clear.

Reset
REQ-031 wb_rst_i=1 SHALL immediately force: state HUNT_LOW, ph=0, ones and loss counters 0, shift register 0, bs_o=0, bs_valid_o=0, locked_o=0, realign_o=0.
REQ-032 bs_restart=1 SHALL apply the same values synchronously, in any state, regardless of fast_enable.

Verification (OSR=5, LOSS_BITS=16, TRACK_EN=1, invert=0, enable every 2nd clk)
REQ-033 Reset, rx_i held 1 for 100 enables -> locked_o=0, bs_valid_o never pulses.
REQ-034 rx_i 0,1,1,1,1 … -> locked_o rises after the 3rd 1; first bs_valid_o with bs_o=1 follows the next enable (ph=3), then every 5 enables.
REQ-035 rx_i 0,1,0,1,1,1 -> remains unlocked through the glitch, locks on the second rising edge; single-sample 0 spike at ph=2 inside a 1 cell -> bs_o=1 (majority).
REQ-036 Locked, then next rising edge delayed by one enable -> realign_o pulses once, and later decisions occur 5 enables apart from the corrected phase; same test for early by one enable; TRACK_EN=0 -> no pulse.
REQ-037 Locked, then rx_i constant for 16 bit cells -> locked_o falls at the 16th wrap, bs_o=0, state HUNT_LOW.
REQ-038 bs_restart asserted with fast_enable in TRACK -> all outputs 0 next clk; wb_rst_i mid-CONFIRM -> outputs 0 asynchronously.
